cache_mem_port: RTL and testbench

- Main-memory side of the cache: the stage directly downstream of the cache controller.
- Accepts the controller's memory strobe and read/write select, then holds the access for a fixed number of wait states.
- Commits writes to, or fetches reads from, an internal word array, and signals completion with a one-cycle ready pulse.
- Models the slow memory whose latency the controller's wait-state counter is sized against.

---
 rtl/cache_mem_port_if.sv | 24 ++
 rtl/cache_mem_port.sv | 110 +++++++++++
 tb/tb_cache_mem_port.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_port_if.sv
// Handshake and data bus between the cache controller and the main-memory port.
interface cache_mem_port_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic [DATA_W-1:0] MDataOut;
  logic              MReady;
  logic              MBusy;
  logic              Overrun;

  modport master (
    output MStrobe, MRW, MAddr, MDataIn,
    input  MDataOut, MReady, MBusy, Overrun
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MDataIn,
    output MDataOut, MReady, MBusy, Overrun
  );
endinterface

// File: rtl/cache_mem_port.sv
// Slow main-memory model: latches one access, waits WAIT_CYCLES, commits it to
// the word array and pulses MReady for one cycle. WAIT_CYCLES must be 1..255.
module cache_mem_port #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned DEPTH       = 2**ADDR_W
) (
  input logic             clk,
  input logic             reset,
  cache_mem_port_if.slave mp
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] dout_q;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              commit_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state, latch and flag logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    ready_d   = 1'b0;
    overrun_d = overrun_q;
    commit_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mp.MStrobe) begin
          addr_d  = mp.MAddr;
          data_d  = mp.MDataIn;
          rw_d    = mp.MRW;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mp.MStrobe) overrun_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          commit_c = 1'b1;
        end
      end
      S_DONE: begin
        if (mp.MStrobe) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      dout_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      if (commit_c && !rw_q) dout_q <= mem[addr_q];
    end
  end

  // Array is not reset; a reset at the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (reset && commit_c && rw_q) mem[addr_q] <= data_q;
  end

  assign mp.MDataOut = dout_q;
  assign mp.MReady   = ready_q;
  assign mp.MBusy    = busy_q;
  assign mp.Overrun  = overrun_q;

endmodule

// File: tb/tb_cache_mem_port.sv
// Directed bench for cache_mem_port: per-cycle vector table on a WAIT_CYCLES=4
// instance, plus a latency sweep on WAIT_CYCLES=1 and WAIT_CYCLES=7 instances.
module tb_cache_mem_port;

  logic clk;
  logic reset;

  cache_mem_port_if #(.ADDR_W(8), .DATA_W(32)) bus4 ();
  cache_mem_port_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();
  cache_mem_port_if #(.ADDR_W(8), .DATA_W(32)) bus7 ();

  cache_mem_port #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .reset(reset), .mp(bus4)
  );
  cache_mem_port #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .mp(bus1)
  );
  cache_mem_port #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(7)) u_w7 (
    .clk(clk), .reset(reset), .mp(bus7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stb;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        chk;
    logic        rdy;
    logic        busy;
    logic [31:0] dout;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void push(logic rst, logic stb, logic rw, logic [7:0] addr,
                               logic [31:0] din, logic chk, logic rdy, logic busy,
                               logic [31:0] dout, logic ov);
    vec_t v;
    v.rst = rst; v.stb = stb; v.rw = rw; v.addr = addr; v.din = din;
    v.chk = chk; v.rdy = rdy; v.busy = busy; v.dout = dout; v.ov = ov;
    vecs.push_back(v);
  endfunction

  // One isolated access: strobe cycle, four wait cycles with scrambled inputs, ready cycle
  function automatic void access(logic rw, logic [7:0] addr, logic [31:0] din,
                                 logic [31:0] dout_pre, logic [31:0] dout_post, logic ov);
    push(1'b1, 1'b1, rw, addr, din, 1'b1, 1'b0, 1'b0, dout_pre, ov);
    for (int k = 1; k <= 4; k++)
      push(1'b1, 1'b0, ~rw, addr ^ 8'(k), ~din ^ 32'(k), 1'b1, 1'b0, 1'b1, dout_pre, ov);
    push(1'b1, 1'b0, ~rw, addr ^ 8'h5, din ^ 32'h5, 1'b1, 1'b1, 1'b1, dout_post, ov);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus4.MStrobe = 1'b0; bus4.MRW = 1'b0; bus4.MAddr = '0; bus4.MDataIn = '0;
    bus1.MStrobe = 1'b0; bus1.MRW = 1'b0; bus1.MAddr = '0; bus1.MDataIn = '0;
    bus7.MStrobe = 1'b0; bus7.MRW = 1'b0; bus7.MAddr = '0; bus7.MDataIn = '0;

    // Reset held two cycles
    push(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    // Write then read back
    access(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    access(1'b0, 8'h10, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    // Overrun: second strobe in WAIT cycle 2 is dropped
    push(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    push(1'b1, 1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    // Reset abort: prewrite 0, start write of 0x1234, reset in WAIT cycle 3
    access(1'b1, 8'h30, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b1, 1'b1, 8'h30, 32'h1234, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    push(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    access(1'b0, 8'h30, 32'h0, 32'h0, 32'h0, 1'b0);
    // Input latching: inputs scrambled during the wait states
    access(1'b1, 8'h40, 32'hAAAA5555, 32'h0, 32'h0, 1'b0);
    access(1'b0, 8'h40, 32'h0, 32'h0, 32'hAAAA5555, 1'b0);
    // Prewrite for back-to-back reads
    access(1'b1, 8'h01, 32'h11, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
    access(1'b1, 8'h02, 32'h22, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
    // MStrobe held high: one access every 6 cycles, alternating addresses
    for (int j = 0; j < 3; j++) begin
      logic [7:0]  a;
      logic [31:0] pre, post;
      logic        ov0;
      a    = (j == 1) ? 8'h02 : 8'h01;
      post = (j == 1) ? 32'h22 : 32'h11;
      pre  = (j == 0) ? 32'hAAAA5555 : ((j == 1) ? 32'h11 : 32'h22);
      ov0  = (j != 0);
      push(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, 1'b0, 1'b0, pre, ov0);
      push(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, 1'b0, 1'b1, pre, ov0);
      for (int k = 2; k <= 4; k++)
        push(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, 1'b0, 1'b1, pre, 1'b1);
      push(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, 1'b1, 1'b1, post, 1'b1);
    end
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h11, 1'b1);
    push(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h11, 1'b1);

    tick();
    foreach (vecs[i]) begin
      reset        = vecs[i].rst;
      bus4.MStrobe = vecs[i].stb;
      bus4.MRW     = vecs[i].rw;
      bus4.MAddr   = vecs[i].addr;
      bus4.MDataIn = vecs[i].din;
      if (vecs[i].chk) begin
        check("w4_ready",   i, 32'(bus4.MReady),  32'(vecs[i].rdy));
        check("w4_busy",    i, 32'(bus4.MBusy),   32'(vecs[i].busy));
        check("w4_dataout", i, bus4.MDataOut,     vecs[i].dout);
        check("w4_overrun", i, 32'(bus4.Overrun), 32'(vecs[i].ov));
      end
      tick();
    end
    bus4.MStrobe = 1'b0;

    // Latency sweep on WAIT_CYCLES=1 and WAIT_CYCLES=7
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("w1_reset_ready", 0, 32'(bus1.MReady), 32'h0);
    check("w7_reset_ready", 0, 32'(bus7.MReady), 32'h0);
    bus1.MStrobe = 1'b1; bus1.MRW = 1'b1; bus1.MAddr = 8'h05; bus1.MDataIn = 32'hCAFE0001;
    bus7.MStrobe = 1'b1; bus7.MRW = 1'b1; bus7.MAddr = 8'h05; bus7.MDataIn = 32'hCAFE0007;
    tick();
    bus1.MStrobe = 1'b0; bus7.MStrobe = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus1.MAddr = 8'(k); bus7.MAddr = 8'(k);
      check("w1_wr_ready", k, 32'(bus1.MReady), 32'(k == 2));
      check("w1_wr_busy",  k, 32'(bus1.MBusy),  32'(k <= 2));
      check("w7_wr_ready", k, 32'(bus7.MReady), 32'(k == 8));
      check("w7_wr_busy",  k, 32'(bus7.MBusy),  32'(k <= 8));
      tick();
    end
    bus1.MStrobe = 1'b1; bus1.MRW = 1'b0; bus1.MAddr = 8'h05;
    bus7.MStrobe = 1'b1; bus7.MRW = 1'b0; bus7.MAddr = 8'h05;
    tick();
    bus1.MStrobe = 1'b0; bus7.MStrobe = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check("w1_rd_ready",   k, 32'(bus1.MReady), 32'(k == 2));
      check("w7_rd_ready",   k, 32'(bus7.MReady), 32'(k == 8));
      check("w1_rd_dataout", k, bus1.MDataOut, (k >= 2) ? 32'hCAFE0001 : 32'h0);
      check("w7_rd_dataout", k, bus7.MDataOut, (k >= 8) ? 32'hCAFE0007 : 32'h0);
      tick();
    end
    check("w1_overrun", 0, 32'(bus1.Overrun), 32'h0);
    check("w7_overrun", 0, 32'(bus7.Overrun), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
